// File: rtl/mem_access_unit.sv
// Byte-serial load/store unit: moves 1, 2 or 4 bytes big-endian over an 8-bit
// memory port, one byte per cycle, with alignment and bounds checking.
module mem_access_unit #(
    parameter int ADDR_LIMIT = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [7:0]  mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [32:0] LIMIT = 33'(ADDR_LIMIT);

    logic [1:0]  state;
    logic        weReg;
    logic        signReg;
    logic        errReg;
    logic [1:0]  sizeReg;
    logic [1:0]  byteIdx;
    logic [1:0]  lastIdx;
    logic [31:0] addrReg;
    logic [31:0] shiftReg;
    logic [31:0] acc;
    logic [31:0] accNext;
    logic [31:0] loadValue;
    logic [31:0] wdataAligned;
    logic [2:0]  reqBytes;
    logic [32:0] reqEnd;
    logic        reqErr;

    // Request decode; the end address is formed in 33 bits so a wrapping
    // address near 2^32 is still caught as out of range.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        reqBytes     = 3'd1;
        wdataAligned = {wdata[7:0], 24'd0};
        case (size)
            2'b01: begin
                reqBytes     = 3'd2;
                wdataAligned = {wdata[15:0], 16'd0};
            end
            2'b10: begin
                reqBytes     = 3'd4;
                wdataAligned = wdata;
            end
            default: ;
        endcase
        reqEnd = {1'b0, addr} + {30'd0, reqBytes};
        reqErr = (size == 2'b11)
              || (size == 2'b01 && addr[0])
              || (size == 2'b10 && addr[1:0] != 2'b00)
              || (reqEnd > LIMIT);
    end

    always_comb begin
        accNext   = {acc[23:0], mem_rdata};
        lastIdx   = 2'd0;
        loadValue = accNext;
        case (sizeReg)
            2'b00: loadValue = {{24{signReg & accNext[7]}}, accNext[7:0]};
            2'b01: begin
                lastIdx   = 2'd1;
                loadValue = {{16{signReg & accNext[15]}}, accNext[15:0]};
            end
            default: lastIdx = 2'd3;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = done & errReg;
    assign mem_read  = (state == XFER) & ~weReg;
    assign mem_write = (state == XFER) & weReg;
    assign mem_addr  = (state == XFER) ? addrReg + {30'd0, byteIdx} : 32'd0;
    assign mem_wdata = mem_write ? shiftReg[31:24] : 8'd0;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state    <= IDLE;
            weReg    <= 1'b0;
            signReg  <= 1'b0;
            errReg   <= 1'b0;
            sizeReg  <= 2'b00;
            byteIdx  <= 2'd0;
            addrReg  <= 32'd0;
            shiftReg <= 32'd0;
            acc      <= 32'd0;
            rdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        weReg    <= we;
                        signReg  <= sign_ext;
                        sizeReg  <= size;
                        addrReg  <= addr;
                        shiftReg <= wdataAligned;
                        acc      <= 32'd0;
                        byteIdx  <= 2'd0;
                        errReg   <= reqErr;
                        state    <= reqErr ? DONE : XFER;
                    end
                end
                XFER: begin
                    if (weReg) shiftReg <= {shiftReg[23:0], 8'd0};
                    else       acc      <= accNext;
                    if (byteIdx == lastIdx) begin
                        state <= DONE;
                        if (!weReg) rdata <= loadValue;
                    end else begin
                        byteIdx <= byteIdx + 2'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random accesses against a byte-array
// reference model with explicit big-endian packing and extension.
module tb_mem_access_unit;

    localparam int ADDR_LIMIT = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem    [256];
    logic [7:0]  refMem [256];
    logic [31:0] expRdata;
    int          tests = 0;
    int          fails = 0;

    mem_access_unit #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access from an IDLE cycle through the following IDLE cycle.
    task automatic runOp(input string tag, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
        int          nb;
        int          expLat;
        int          lat;
        int          k;
        logic        expErr;
        logic [63:0] endA;
        logic [31:0] v;

        nb     = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        endA   = 64'(a) + 64'(nb);
        expErr = (sz == 2'b11) || (sz == 2'b01 && a[0])
              || (sz == 2'b10 && a[1:0] != 2'b00) || (endA > 64'(ADDR_LIMIT));
        expLat = expErr ? 1 : 1 + nb;
        if (!expErr) begin
            if (w) begin
                for (int i = 0; i < nb; i++) refMem[int'(a) + i] = wd[8*(nb-1-i) +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = (v << 8) | 32'(refMem[int'(a) + i]);
                if (nb == 1 && sx && v[7])  v = v | 32'hFFFF_FF00;
                if (nb == 2 && sx && v[15]) v = v | 32'hFFFF_0000;
                expRdata = v;
            end
        end

        we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        k   = 0;
        while (!done && lat < 20) begin
            // Scramble inputs: the unit must work from its latched copy and ignore req.
            req = 1'($urandom); we = 1'($urandom); size = 2'($urandom);
            addr = $urandom; wdata = $urandom; sign_ext = 1'($urandom);
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " both strobes"}, 32'(mem_read & mem_write), 32'd0);
            if (mem_read || mem_write) begin
                check({tag, " dir"}, 32'(mem_write), 32'(w));
                check({tag, " addr"}, mem_addr, a + 32'(k));
                if (w && k < nb) check({tag, " wbyte"}, 32'(mem_wdata), 32'(wd[8*(nb-1-k) +: 8]));
                k++;
            end
            @(posedge clk); #1;
            lat++;
        end
        req = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(expLat));
        check({tag, " err"}, 32'(err), 32'(expErr));
        check({tag, " strobes"}, 32'(k), expErr ? 32'd0 : 32'(nb));
        check({tag, " rdata"}, rdata, expRdata);
        check({tag, " done strobes"}, 32'({mem_read, mem_write}), 32'd0);
        @(posedge clk); #1;
        check({tag, " idle"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        logic [7:0] pre [8];
        logic [7:0] b;
        int         bad;
        logic       sawDone;
        logic [1:0] rs;
        logic [31:0] ra;

        pre = '{8'h01, 8'h1C, 8'h04, 8'hEE, 8'h31, 8'h42, 8'hDF, 8'hCC};
        for (int i = 0; i < 256; i++) begin
            b = (i < 8) ? pre[i] : 8'($urandom);
            mem[i]    <= b;
            refMem[i]  = b;
        end
        expRdata = 32'd0;
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst strobes", 32'({mem_read, mem_write}), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        runOp("ld_w0", 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        check("ld_w0 const", rdata, 32'h011C_04EE);
        runOp("ld_h6s", 1'b0, 2'b01, 1'b1, 32'd6, 32'd0);
        check("ld_h6s const", rdata, 32'hFFFF_DFCC);
        runOp("ld_h6z", 1'b0, 2'b01, 1'b0, 32'd6, 32'd0);
        check("ld_h6z const", rdata, 32'h0000_DFCC);
        runOp("ld_b3s", 1'b0, 2'b00, 1'b1, 32'd3, 32'd0);
        check("ld_b3s const", rdata, 32'hFFFF_FFEE);
        runOp("st_w8", 1'b1, 2'b10, 1'b0, 32'd8, 32'hAABB_CCDD);
        check("st_w8 mem", {mem[8], mem[9], mem[10], mem[11]}, 32'hAABB_CCDD);
        check("st_w8 rdata kept", rdata, 32'hFFFF_FFEE);
        runOp("ld_w2", 1'b0, 2'b10, 1'b0, 32'd2, 32'd0);
        runOp("ld_w158", 1'b0, 2'b10, 1'b0, 32'd158, 32'd0);
        runOp("ld_b159", 1'b0, 2'b00, 1'b0, 32'd159, 32'd0);
        runOp("ld_h_wrap", 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFE, 32'd0);
        runOp("size11", 1'b0, 2'b11, 1'b0, 32'd0, 32'd0);

        for (int n = 0; n < 60; n++) begin
            rs = 2'($urandom);
            ra = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                             : 32'($urandom_range(0, ADDR_LIMIT + 3));
            if ($urandom_range(0, 3) != 0 && rs == 2'b10) ra[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0 && rs == 2'b01) ra[0] = 1'b0;
            runOp($sformatf("rnd%0d", n), 1'($urandom), rs, 1'($urandom), ra, $urandom);
        end

        bad = 0;
        for (int i = 0; i < ADDR_LIMIT; i++) if (mem[i] !== refMem[i]) bad++;
        check("mem image", 32'(bad), 32'd0);

        // Abort a word load in its second transfer cycle.
        we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'd0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("abort pre read", 32'(mem_read), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        expRdata = 32'd0;
        check("abort strobes", 32'({mem_read, mem_write}), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort rdata", rdata, 32'd0);
        sawDone = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || busy) sawDone = 1'b1;
        end
        check("abort no done", 32'(sawDone), 32'd0);

        runOp("post_abort", 1'b0, 2'b10, 1'b0, 32'd4, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 160, meaning the memory size in bytes; valid byte addresses are 0..ADDR_LIMIT-1.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset: reset==0 at a rising clk edge resets the block.
REQ-004 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-005 SHALL have port we  input  1  1=store, 0=load.
REQ-006 SHALL have port size  input  2  00=byte, 01=halfword, 10=word; 11 is treated as an error.
REQ-007 SHALL have port sign_ext  input  1  load only: 1=sign-extend, 0=zero-extend.
REQ-008 SHALL have port addr  input  32  byte address of the access.
REQ-009 SHALL have port wdata  input  32  store data, right-justified for byte/halfword.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  valid with done; 1 = access rejected.
REQ-013 SHALL have port rdata  output  32  load result, held until the next done.
REQ-014 SHALL have port mem_addr  output  32  byte address to memory.
REQ-015 SHALL have port mem_wdata  output  8  byte to memory.
REQ-016 SHALL have port mem_read  output  1  byte read strobe.
REQ-017 SHALL have port mem_write  output  1  byte write strobe.
REQ-018 SHALL have port mem_rdata  input  8  byte from memory, valid combinationally in the same cycle as mem_read.

Function
REQ-019 SHALL implement the FSM IDLE -> XFER -> DONE -> IDLE, with IDLE -> DONE taken directly on error.
REQ-020 SHALL, in IDLE with req=1, latch we, size, sign_ext, addr and wdata; a req in any other state SHALL be ignored.
REQ-021 SHALL flag an error if: size==11; halfword with addr[0]!=0; word with addr[1:0]!=0; or addr+nbytes > ADDR_LIMIT, computed without 32-bit wrap.
REQ-022 SHALL, on error, go to DONE with no mem_read or mem_write strobe and leave rdata unchanged.
REQ-023 SHALL use nbytes = 1, 2 or 4; XFER SHALL last exactly nbytes cycles, one byte per cycle, with the byte index k running 0..nbytes-1.
REQ-024 SHALL drive mem_addr = addr+k during XFER, and 0 in all other states.
REQ-025 SHALL use big-endian byte order: the lowest address holds the most-significant byte.
REQ-026 SHALL, on a load, assert mem_read during each XFER cycle and shift mem_rdata into a 32-bit accumulator as acc <= {acc[23:0], mem_rdata}.
REQ-027 SHALL, on a store, assert mem_write during each XFER cycle with mem_wdata = wdata[8*(nbytes-1-k)+7 : 8*(nbytes-1-k)].
REQ-028 SHALL never assert mem_read and mem_write together, nor either strobe outside XFER.
REQ-029 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE; on a successful load, rdata SHALL be updated on the edge entering DONE, sign- or zero-extended from 8 or 16 bits.
REQ-030 SHALL leave rdata unchanged on a store.
REQ-031 SHALL give these latencies, counted from the req edge to the done cycle: byte 2 cycles, halfword 3 cycles, word 5 cycles, error 1 cycle.
REQ-032 SHALL accept a new req in the cycle after done (back-to-back), because that cycle is IDLE.

Reset
REQ-033 SHALL, on reset==0 at a clk edge, enter IDLE and clear busy, done, err, rdata, mem_addr, mem_wdata, mem_read and mem_write to 0.
REQ-034 SHALL, on reset during XFER, abort the access: strobes drop from the next cycle and no done is produced.

Verification (bench memory model preloaded with bytes 0..7 = 01 1C 04 EE 31 42 DF CC)
REQ-035 SHALL verify: word load at addr 0 -> 4 mem_read cycles on addresses 0..3, done 5 cycles after req, rdata=0x011C04EE, err=0.
REQ-036 SHALL verify: halfword load at addr 6 with sign_ext=1 -> rdata=0xFFFFDFCC; the same load with sign_ext=0 -> rdata=0x0000DFCC.
REQ-037 SHALL verify: byte load at addr 3 with sign_ext=1 -> rdata=0xFFFFFFEE, done 2 cycles after req.
REQ-038 SHALL verify: word store of 0xAABBCCDD at addr 8 -> memory bytes 8..11 become AA BB CC DD, 4 mem_write strobes, rdata unchanged.
REQ-039 SHALL verify: word load at addr 2, and word load at addr 158 -> each gives done with err=1 in 1 cycle and no strobes.
REQ-040 SHALL verify: reset=0 in the second XFER cycle of a word load -> strobes low from the next cycle, no done, busy=0.
